// File: rtl/user_mem64x8_io.sv
// 64x8 read/write memory driven entirely from the user I/O pads.
// Registered read port; write wins over read when both enables are set.
module user_mem64x8_io #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    localparam logic [37:0] OUT_MASK = 38'h00_00FF_0010;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic              w_rd_en;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_rd_valid;
    logic [37:0]       w_out;

    // Assert immediately, release two clock edges after resetb rises.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_rd_en = io_in[0];
    assign w_wr_en = io_in[3];
    assign w_wdata = io_in[15:8];
    assign w_addr  = io_in[30:25];

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_wr_en) begin
            r_mem[w_addr] <= w_wdata;
            r_rd_valid    <= 1'b0;
        end else if (w_rd_en) begin
            r_rdata    <= r_mem[w_addr];
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    always_comb begin
        w_out        = '0;
        w_out[23:16] = r_rdata;
        w_out[4]     = r_rd_valid;
    end

    assign io_out = w_out;
    assign io_oeb = ~OUT_MASK;

endmodule

// File: tb/tb_user_mem64x8_io.sv
// Scoreboard bench for user_mem64x8_io: directed plan, then random traffic
// checked against a plain array model of the memory.
module tb_user_mem64x8_io;

    logic        clk;
    logic        resetb;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    int total = 0;
    int bad   = 0;

    logic [37:0] exp_q [$];
    logic [7:0]  model_mem [64];
    logic [7:0]  model_rdata;
    logic [37:0] exp_oeb;

    user_mem64x8_io dut (
        .clock  (clk),
        .resetb (resetb),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [37:0] a, input logic [37:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [37:0] mk_out(input logic v, input logic [7:0] d);
        logic [37:0] o;
        o        = '0;
        o[23:16] = d;
        o[4]     = v;
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
        model_rdata = 8'h00;
    endtask

    // One cycle of stimulus; ignored pad bits carry random garbage.
    task automatic drive(input bit rd, input bit wr, input logic [5:0] a, input logic [7:0] d);
        logic [63:0] rnd;
        logic [37:0] v;
        logic        ev;
        @(negedge clk);
        rnd      = {$urandom(), $urandom()};
        v        = rnd[37:0];
        v[0]     = rd;
        v[3]     = wr;
        v[15:8]  = d;
        v[30:25] = a;
        io_in    = v;
        ev       = 1'b0;
        if (wr) begin
            model_mem[a] = d;
        end else if (rd) begin
            model_rdata = model_mem[a];
            ev          = 1'b1;
        end
        exp_q.push_back(mk_out(ev, model_rdata));
    endtask

    initial begin
        logic [37:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("io_out", io_out, e);
            end else if (io_out[4]) begin
                total++;
                bad++;
                $display("FAIL spurious_valid: got %h expected valid=0", io_out);
            end
        end
    end

    initial begin
        bit        rd;
        bit        wr;
        logic [5:0] a;
        exp_oeb = '1;
        for (int i = 16; i < 24; i++) exp_oeb[i] = 1'b0;
        exp_oeb[4] = 1'b0;

        io_in  = '0;
        resetb = 1'b0;
        model_reset();
        #2000;
        chk("reset_out", io_out, 38'h0);
        chk("reset_oeb", io_oeb, exp_oeb);
        @(posedge clk);
        #3;
        resetb = 1'b1;
        repeat (4) drive(0, 0, 6'h00, 8'h00);
        chk("oeb_run", io_oeb, exp_oeb);

        drive(0, 1, 6'h39, 8'hFA);
        drive(0, 1, 6'h18, 8'hEA);
        drive(1, 0, 6'h39, 8'h6A);
        drive(1, 0, 6'h18, 8'h00);
        drive(0, 0, 6'h18, 8'h00);
        drive(0, 0, 6'h2A, 8'h11);
        drive(1, 0, 6'h39, 8'h00);
        drive(0, 1, 6'h00, 8'h55);
        drive(1, 0, 6'h00, 8'h00);
        drive(1, 1, 6'h3F, 8'hA5);
        drive(0, 0, 6'h00, 8'h00);
        drive(1, 0, 6'h3F, 8'h00);
        drive(1, 0, 6'h39, 8'h00);
        drive(0, 0, 6'h00, 8'h00);

        @(posedge clk);
        #3;
        resetb = 1'b0;
        #1;
        chk("async_reset_out", io_out, 38'h0);
        model_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        resetb = 1'b1;
        repeat (3) drive(0, 0, 6'h00, 8'h00);
        drive(1, 0, 6'h39, 8'h00);
        drive(1, 0, 6'h3F, 8'h00);
        drive(0, 0, 6'h00, 8'h00);

        for (int k = 0; k < 400; k++) begin
            rd = ($urandom_range(0, 99) < 55);
            wr = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 1) == 1) a = 6'($urandom_range(0, 7));
            else a = 6'($urandom_range(0, 63));
            drive(rd, wr, a, 8'($urandom));
        end
        for (int a2 = 0; a2 < 64; a2++) drive(1, 0, 6'(a2), 8'($urandom));
        drive(0, 0, 6'h00, 8'h00);

        for (int t = 0; t < 10; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
